// File: rtl/md_unit_pipe.sv
// md_unit_pipe - multiply/divide unit for the E stage of the pipelined MIPS datapath.
//
// Holds the architectural HI/LO registers and runs signed/unsigned multiply and
// divide with independently configurable latencies. An in-flight operation can be
// aborted with `cancel` without disturbing HI/LO.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : mod 6 = MADD, mod 7 = MSUB (accumulate into {hi,lo})
//   undefined : mod 6/7 are no-ops and no accumulate logic is built
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   start   in   operation request, sampled at the rising edge
//   mod     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   d1      in   rs operand (also MTHI/MTLO source)
//   d2      in   rt operand
//   cancel  in   abort the in-flight operation
//   busy    out  registered; high while an operation is in flight
//   hi, lo  out  architectural HI/LO
//
// state  | meaning
// S_IDLE | no operation in flight; accepts start (long ops, MTHI/MTLO)
// S_RUN  | counting down the op latency; pend_hi/pend_lo commit when cnt reaches 1

module md_unit_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mod,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   num;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   den_nz;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               op_long;
  logic [CW-1:0]      op_cnt;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
`endif

  // Products: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH bits of the
  // product are exact for both interpretations.
  always_comb begin
    prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
    prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
  end

  // One shared unsigned divider. Signed division runs on magnitudes and is then
  // sign-corrected, which also yields MIN/-1 = MIN rem 0 without a special case.
  always_comb begin
    if (mod[0]) begin
      num = d1;
      den = d2;
    end else begin
      num = d1[WIDTH-1] ? -d1 : d1;
      den = d2[WIDTH-1] ? -d2 : d2;
    end
    // Keep the divider away from a zero divisor; that result is discarded anyway.
    den_nz = (den == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : den;
    quo    = num / den_nz;
    rem    = num % den_nz;
    div_q  = quo;
    div_r  = rem;
    if (!mod[0]) begin
      if (d1[WIDTH-1] ^ d2[WIDTH-1]) div_q = -quo;
      if (d1[WIDTH-1])               div_r = -rem;
    end
  end

`ifdef MDU_MADD_EN
  // Accumulate base is HI/LO as seen at the start edge.
  always_comb begin
    if (mod[0]) acc = {hi, lo} - prod_s;
    else        acc = {hi, lo} + prod_s;
  end
`endif

  always_comb begin
    res_hi  = hi;
    res_lo  = lo;
    op_long = 1'b0;
    op_cnt  = '0;
    case (mod)
      3'd0: begin
        {res_hi, res_lo} = prod_s;
        op_long = 1'b1;
        op_cnt  = CW'(MULT_CYCLES);
      end
      3'd1: begin
        {res_hi, res_lo} = prod_u;
        op_long = 1'b1;
        op_cnt  = CW'(MULT_CYCLES);
      end
      3'd2, 3'd3: begin
        // Divisor zero leaves HI/LO unchanged but still takes the full latency.
        if (d2 != '0) begin
          res_hi = div_r;
          res_lo = div_q;
        end
        op_long = 1'b1;
        op_cnt  = CW'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      3'd6, 3'd7: begin
        {res_hi, res_lo} = acc;
        op_long = 1'b1;
        op_cnt  = CW'(MULT_CYCLES);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // cancel beats start, including MTHI/MTLO
          if (start && !cancel) begin
            if (op_long) begin
              state   <= S_RUN;
              busy    <= 1'b1;
              cnt     <= op_cnt;
              pend_hi <= res_hi;
              pend_lo <= res_lo;
            end else if (mod == 3'd4) begin
              hi <= d1;
            end else if (mod == 3'd5) begin
              lo <= d1;
            end
          end
        end
        S_RUN: begin
          // start is ignored here; cancel also suppresses a same-edge commit
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_pipe.sv
// tb_md_unit_pipe - self-checking bench for md_unit_pipe (WIDTH=32, MULT 5, DIV 10).
// Directed cases from the datasheet examples followed by randomized operations,
// all checked against a 64-bit integer reference model of HI/LO.

module tb_md_unit_pipe;

  localparam int W    = 32;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   mod;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic         cancel;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  md_unit_pipe #(.WIDTH(W), .MULT_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst), .start(start), .mod(mod), .d1(d1), .d2(d2),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what HI/LO become after the op and how many busy cycles it takes.
  function automatic void model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    nh = h;
    nl = l;
    n  = 0;
    case (m)
      3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; n = MULC; end
      3'd1: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; n = MULC; end
      3'd2: begin
        n = DIVC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      3'd3: begin
        n = DIVC;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; nl = uq[31:0]; nh = ur[31:0]; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: begin
`ifdef MDU_MADD_EN
        if (m == 3'd6) p = {h, l} + sa * sb;
        else           p = {h, l} - sa * sb;
        nh = p[63:32];
        nl = p[31:0];
        n  = MULC;
`endif
      end
    endcase
  endfunction

  // Issue one op and follow it to completion. cancel_at=k (1..n) asserts cancel
  // during the k-th busy cycle; 0 or beyond the latency means no cancel.
  task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at);
    logic [31:0] nh, nl;
    int          n;
    bit          cancelled;
    model(m, a, b, m_hi, m_lo, nh, nl, n);
    cancelled = 1'b0;
    @(negedge clk);
    start = 1'b1; mod = m; d1 = a; d2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("busy_m%0d_c%0d", m, k), busy, 1);
      if (k == cancel_at) cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      if (k == cancel_at) begin
        cancelled = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!cancelled) begin
      m_hi = nh;
      m_lo = nl;
    end
    chk($sformatf("idle_m%0d", m), busy, 0);
    chk($sformatf("hi_m%0d", m), hi, m_hi);
    chk($sformatf("lo_m%0d", m), lo, m_lo);
  endtask

  initial begin
    int          nb;
    logic [2:0]  rm;
    logic [31:0] ra, rb;
    int          pick, ca;

    rst = 1'b0; start = 1'b0; cancel = 1'b0; mod = '0; d1 = '0; d2 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd2, 0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    run_op(3'd4, 32'h11, 32'd0, 0);
    run_op(3'd5, 32'h22, 32'd0, 0);
    run_op(3'd2, 32'd1234, 32'd0, 0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    run_op(3'd4, 32'd0, 32'd0, 0);
    run_op(3'd5, 32'd0, 32'd0, 0);
    run_op(3'd0, 32'd3, 32'd4, 3);
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd0);

    // MTHI together with cancel in IDLE is dropped
    @(negedge clk);
    start = 1'b1; mod = 3'd4; d1 = 32'h55; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("idlecancel_hi", hi, m_hi);
    chk("idlecancel_busy", busy, 0);

    // second start during RUN is ignored
    @(negedge clk);
    start = 1'b1; mod = 3'd0; d1 = 32'd6; d2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (c == 2) begin start = 1'b1; d1 = 32'd9; d2 = 32'd9; end
      @(posedge clk);
      #1 start = 1'b0;
    end
    m_hi = 32'd0; m_lo = 32'd42;
    chk("ign_busy_len", nb, MULC);
    chk("ign_hi", hi, m_hi);
    chk("ign_lo", lo, m_lo);

    // async reset in busy cycle 4 of a divide
    run_op(3'd4, 32'h77, 32'd0, 0);
    @(negedge clk);
    start = 1'b1; mod = 3'd3; d1 = 32'd100; d2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (DIVC + 3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);

`ifdef MDU_MADD_EN
    run_op(3'd5, 32'd10, 32'd0, 0);
    run_op(3'd6, 32'd3, 32'd4, 0);
    chk("madd_lo", lo, 32'd22);
    chk("madd_hi", hi, 32'd0);
    run_op(3'd7, 32'd5, 32'd5, 0);
    chk("msub_hi", hi, 32'hFFFF_FFFF);
    chk("msub_lo", lo, 32'hFFFF_FFFD);
`else
    run_op(3'd5, 32'd10, 32'd0, 0);
    run_op(3'd6, 32'd3, 32'd4, 0);
    chk("nomadd_lo", lo, 32'd10);
    chk("nomadd_hi", hi, 32'd0);
`endif

    for (int i = 0; i < 80; i++) begin
      rm   = 3'($urandom_range(0, 7));
      ra   = $urandom;
      pick = $urandom_range(0, 5);
      case (pick)
        0: rb = 32'd0;
        1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ca = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DIVC) : 0;
      run_op(rm, ra, rb, ca);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
